ysyx_23060201_lsu: RTL and testbench

//  Load/store unit between EXU and the data-memory block (DPI pmem_read/pmem_write wrapper).

---
 rtl/ysyx_23060201_lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one op in flight, IDLE -> REQ -> WAIT -> RESP, fixed memory latency MEM_LAT.
// Optional feature macro: YSYX_23060201_LSU_MISALIGN_TRAP_EN (misaligned h/w ops respond with out_err, no memory access).
module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  // funct3[1:0]: 00 byte, 01 half, 1x word (illegal encodings fall into the word case)
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] base;
    case (f3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h000000, sh[7:0]};
      3'b101:  return {16'h0000, sh[15:0]};
      default: return sh;
    endcase
  endfunction

`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || (f3[1] && (off != 2'b00));
  endfunction
`endif

  state_t                  state_r, state_s;
  logic                    is_store_r, is_store_s;
  logic [2:0]              funct3_r, funct3_s;
  logic [1:0]              off_r, off_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0]   rdata_r, rdata_s;
  logic                    err_r, err_s;
  logic                    ren_r, ren_s, wen_r, wen_s;
  logic [ADDR_WIDTH-1:0]   raddr_r, raddr_s, waddr_r, waddr_s;
  logic [3:0]              rmask_r, rmask_s, wmask_r, wmask_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic                    accept_s, trap_s;

  assign accept_s = in_valid && (state_r == IDLE);

`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
  assign trap_s = is_misaligned(in_funct3, in_addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = trap_s ? RESP : REQ;
        else          state_s = IDLE;
      end
      REQ:  state_s = is_store_r ? RESP : WAIT;
      WAIT: begin
        if (cnt_r == CNT_LAST) state_s = RESP;
        else                   state_s = WAIT;
      end
      RESP: begin
        if (out_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the op latches and registered outputs
  always_comb begin
    is_store_s = is_store_r;
    funct3_s   = funct3_r;
    off_s      = off_r;
    cnt_s      = cnt_r;
    rdata_s    = rdata_r;
    err_s      = err_r;
    ren_s      = ren_r;
    wen_s      = wen_r;
    raddr_s    = raddr_r;
    waddr_s    = waddr_r;
    rmask_s    = rmask_r;
    wmask_s    = wmask_r;
    wdata_s    = wdata_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          is_store_s = in_is_store;
          funct3_s   = in_funct3;
          off_s      = in_addr[1:0];
          cnt_s      = '0;
          rdata_s    = '0;
          err_s      = trap_s || is_illegal(in_funct3);
          if (!trap_s && in_is_store) begin
            wen_s   = 1'b1;
            waddr_s = {in_addr[ADDR_WIDTH-1:2], 2'b00};
            wmask_s = lane_mask(in_funct3, in_addr[1:0]);
            wdata_s = in_wdata << {in_addr[1:0], 3'b000};
          end else if (!trap_s) begin
            ren_s   = 1'b1;
            raddr_s = {in_addr[ADDR_WIDTH-1:2], 2'b00};
            rmask_s = lane_mask(in_funct3, in_addr[1:0]);
          end else begin
            ren_s = 1'b0;
            wen_s = 1'b0;
          end
        end else begin
          cnt_s = '0;
        end
      end
      REQ: begin
        wen_s = 1'b0;
      end
      WAIT: begin
        if (cnt_r == CNT_LAST) begin
          rdata_s = extract(funct3_r, off_r, mem_rdata);
          ren_s   = 1'b0;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      RESP: begin
        ren_s = 1'b0;
        wen_s = 1'b0;
      end
      default: begin
        ren_s = 1'b0;
        wen_s = 1'b0;
      end
    endcase
  end

  // Op latches and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_r <= 1'b0;
      funct3_r   <= 3'b000;
      off_r      <= 2'b00;
      cnt_r      <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      ren_r      <= 1'b0;
      wen_r      <= 1'b0;
      raddr_r    <= '0;
      waddr_r    <= '0;
      rmask_r    <= 4'b0000;
      wmask_r    <= 4'b0000;
      wdata_r    <= '0;
    end else begin
      is_store_r <= is_store_s;
      funct3_r   <= funct3_s;
      off_r      <= off_s;
      cnt_r      <= cnt_s;
      rdata_r    <= rdata_s;
      err_r      <= err_s;
      ren_r      <= ren_s;
      wen_r      <= wen_s;
      raddr_r    <= raddr_s;
      waddr_r    <= waddr_s;
      rmask_r    <= rmask_s;
      wmask_r    <= wmask_s;
      wdata_r    <= wdata_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == RESP);
  assign out_rdata = rdata_r;
  assign out_err   = err_r;
  assign mem_ren   = ren_r;
  assign mem_raddr = raddr_r;
  assign mem_rmask = {4'b0000, rmask_r};
  assign mem_wen   = wen_r;
  assign mem_waddr = waddr_r;
  assign mem_wmask = {4'b0000, wmask_r};
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for ysyx_23060201_lsu: vector table plus backpressure, reset and store/load sequences.
module tb_ysyx_23060201_lsu;
  localparam int LAT = 3;
  localparam int LL  = LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_rdata, mem_wdata;
  logic [7:0]  mem_rmask, mem_wmask;

  always #5 clk = ~clk;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata)
  );

  // Small data memory: 16 words indexed by addr[5:2]
  logic [31:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_data = 32'h0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;

  assign mem_rdata = mem_ren ? mem[mem_raddr[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output logic acc,
                       output logic [7:0] mask, output logic [31:0] maddr, output logic [31:0] mwd);
    issue(st, f3, a, wd);
    acc   = mem_ren | mem_wen;
    mask  = st ? mem_wmask : mem_rmask;
    maddr = st ? mem_waddr : mem_raddr;
    mwd   = mem_wdata;
    lat   = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = out_rdata;
    er = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic        acc;
    logic [7:0]  mask;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t v[10];

  initial begin
    logic [31:0] rd, maddr, mwd, r0, w0;
    logic        er, acc;
    logic [7:0]  mask;
    int          lat, k;

    v[0] = '{1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 1'b1, 8'h08, 32'h0, 32'hFFFFFF80, 1'b0, LL};
    v[1] = '{1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FF1234, 1'b1, 8'h08, 32'h0, 32'h00000080, 1'b0, LL};
    v[2] = '{1'b1, 3'b001, 32'h80000002, 32'h0000BEEF, 32'h0, 1'b1, 8'h0C, 32'hBEEF0000, 32'h0, 1'b0, 2};
    v[3] = '{1'b0, 3'b101, 32'h80000000, 32'h0, 32'h80FF1234, 1'b1, 8'h03, 32'h0, 32'h00001234, 1'b0, LL};
    v[4] = '{1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80FF1234, 1'b1, 8'h0C, 32'h0, 32'hFFFF80FF, 1'b0, LL};
    v[5] = '{1'b0, 3'b010, 32'h80000004, 32'h0, 32'h12345678, 1'b1, 8'h0F, 32'h0, 32'h12345678, 1'b0, LL};
    v[6] = '{1'b1, 3'b000, 32'h80000001, 32'h000000AB, 32'h0, 1'b1, 8'h02, 32'h0000AB00, 32'h0, 1'b0, 2};
    v[7] = '{1'b0, 3'b011, 32'h80000008, 32'h0, 32'hCAFEF00D, 1'b1, 8'h0F, 32'h0, 32'hCAFEF00D, 1'b1, LL};
`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
    v[8] = '{1'b0, 3'b010, 32'h80000001, 32'h0, 32'h80FF1234, 1'b0, 8'h00, 32'h0, 32'h00000000, 1'b1, 1};
`else
    v[8] = '{1'b0, 3'b010, 32'h80000001, 32'h0, 32'h80FF1234, 1'b1, 8'h0E, 32'h0, 32'h0080FF12, 1'b0, LL};
`endif
    v[9] = '{1'b0, 3'b000, 32'h80000001, 32'h0, 32'h80FF1234, 1'b1, 8'h02, 32'h0, 32'h00000012, 1'b0, LL};

    rst_n = 1'b0; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
    in_addr = 32'h0; in_wdata = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_mem_en", {30'b0, mem_ren, mem_wen}, 32'h0);
    chk("reset_rdata", out_rdata, 32'h0);
    chk("reset_wmask", {24'b0, mem_wmask}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      preload(v[i].addr[5:2], v[i].mword);
      do_op(v[i].st, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat, acc, mask, maddr, mwd);
      chk($sformatf("v%0d_rdata", i), rd, v[i].rdata);
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, v[i].err});
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_access", i), {31'b0, acc}, {31'b0, v[i].acc});
      if (v[i].acc) begin
        chk($sformatf("v%0d_mask", i), {24'b0, mask}, {24'b0, v[i].mask});
        chk($sformatf("v%0d_addr", i), maddr, {v[i].addr[31:2], 2'b00});
      end
      if (v[i].st) chk($sformatf("v%0d_wdata", i), mwd, v[i].mwdata);
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
    end

    // lhu with backpressure: result stays put and in_ready stays low
    preload(4'd0, 32'h80FF1234);
    r0 = ren_cnt;
    issue(1'b0, 3'b101, 32'h80000000, 32'h0);
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", k, LL);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_valid_%0d", c), {31'b0, out_valid}, 32'h1);
      chk($sformatf("bp_rdata_%0d", c), out_rdata, 32'h00001234);
      chk($sformatf("bp_in_ready_%0d", c), {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {31'b0, in_ready}, 32'h1);
    chk("bp_valid_after", {31'b0, out_valid}, 32'h0);
    chk("bp_ren_cycles", ren_cnt - r0, LAT + 1);

    // Async reset in the middle of WAIT
    issue(1'b0, 3'b010, 32'h80000000, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ren", {31'b0, mem_ren}, 32'h0);
    chk("rst_mid_raddr", mem_raddr, 32'h0);
    chk("rst_mid_rmask", {24'b0, mem_rmask}, 32'h0);
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 3'b010, 32'h80000000, 32'h0, rd, er, lat, acc, mask, maddr, mwd);
    chk("post_rst_lw", rd, 32'h80FF1234);
    chk("post_rst_lat", lat, LL);

    // Back-to-back sw then lw on the same word
    preload(4'd4, 32'h0);
    w0 = wen_cnt;
    do_op(1'b1, 3'b010, 32'h80000010, 32'hDEADBEEF, rd, er, lat, acc, mask, maddr, mwd);
    chk("sw_rdata", rd, 32'h0);
    do_op(1'b0, 3'b010, 32'h80000010, 32'h0, rd, er, lat, acc, mask, maddr, mwd);
    chk("sw_lw_data", rd, 32'hDEADBEEF);
    chk("sw_wen_pulses", wen_cnt - w0, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
